ex_iter_divider: RTL and testbench
==================================

Name: ex_iter_divider

Overview:
- Multi-cycle 32-bit integer divider in the EX stage. Executes div.w / mod.w / div.wu / mod.wu.
- Feeds the EX result and a busy indication into the EX bypass bus.
- While an operation is in flight, EX holds the instruction and the data-hazard detector sees an unresolved EX producer.
- Radix-2 restoring algorithm on operand magnitudes, with sign fix-up at the end.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  EX presents a divide operation.
- in_ready  output  1  divider can accept an operation (IDLE only).
- op_signed  input  1  1 = div.w/mod.w, 0 = div.wu/mod.wu.
- op_mod  input  1  1 = return remainder, 0 = return quotient.
- src1  input  XLEN  dividend.
- src2  input  XLEN  divisor.
- cancel  input  1  flush from exception/ertn; aborts the current operation.
- busy  output  1  operation accepted and result not yet consumed; EX ORs this into its stall.
- out_valid  output  1  result valid.
- out_ready  input  1  EX consumes the result.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Reset values (async, resetn low): state = IDLE, in_ready = 1, busy = 0, out_valid = 0, result = 0, counter = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready (and no cancel), latch:
    - |src1|, |src2| (magnitude only when op_signed and the operand's MSB is 1)
    - quotient sign = src1[31] ^ src2[31] when signed
    - remainder sign = src1[31] when signed
    - op_mod
    Then go to CALC with counter = 0. busy rises the cycle after acceptance.
  - CALC: one restoring step per cycle: shift {rem, quo} left by 1, trial-subtract divisor, set quotient bit if no borrow. After 32 steps (counter == 31) go to DONE.
  - DONE: apply the sign fix-up, drive result, out_valid = 1. Hold result and out_valid stable until out_ready, then return to IDLE the next cycle. busy falls with that transition.
- Latency: out_valid asserts exactly 33 cycles after the accept edge (32 CALC + 1 DONE entry) when out_ready is held high.
- Divisor == 0: the full 32 cycles still run. Result is overridden to quotient = 0xFFFFFFFF and remainder = src1, for both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. No trap.
- Remainder sign follows the dividend. Zero results are never negated.
- cancel is honoured in any state. Next edge: state = IDLE, out_valid = 0, busy = 0, result is not updated. An in_valid in the same cycle as cancel is ignored.
- in_ready is 0 in CALC and DONE. Back-to-back operations therefore have a minimum 1-cycle IDLE gap after out_ready.
- Width rule: internal remainder register is XLEN+1 bits so the trial subtract keeps its borrow; counter wraps only on the IDLE reload.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if divisor == 0 or |src1| < |src2| (unsigned magnitude compare), skip CALC and go straight to DONE. out_valid then asserts 1 cycle after the accept edge, with:
  - quotient = 0 (or 0xFFFFFFFF when divisor is 0)
  - remainder = src1
- Undefined: every operation takes the full 33-cycle latency.
- Results are identical either way; only latency differs.

Decomposition:
- macro.vh holds:
  - DIV_IDLE / DIV_CALC / DIV_DONE 2-bit state encodings.
  - DIV_ITER = 32.
  - EX_BYPASS_LEN update if busy is carried on the EX bypass bus.
- One sub-module, div_restoring_core: the unsigned XLEN-iteration shift/subtract datapath plus counter, with start/cancel/finish pins. The sign handling, special-case overrides and handshake stay in ex_iter_divider.

Test Plan:
- Unsigned 100 / 7 with op_mod = 0, then op_mod = 1 → result 14, then 2; out_valid exactly 33 cycles after accept.
- Signed -7 / 2 → quotient 0xFFFFFFFD (-3); mod → 0xFFFFFFFF (-1). Signed 7 / -2 → quotient -3, remainder 1.
- Divide by zero, signed and unsigned, src1 = 0x12345678 → quotient 0xFFFFFFFF, remainder 0x12345678.
- 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0. Unsigned → quotient 0, remainder 0x80000000.
- Backpressure and cancel:
  - Hold out_ready low 5 cycles after out_valid → result stable, busy = 1 throughout.
  - Assert cancel at CALC cycle 10 → out_valid never rises; in_ready = 1 next cycle; the next op 9 / 3 returns 3.
- Pulse resetn low mid-CALC (asynchronously, between edges) → outputs immediately return to reset values. With DIV_EARLY_OUT_EN defined, 3 / 10 → quotient 0 on the cycle after accept.

Source files
------------

// File: rtl/ex_iter_divider_pkg.sv
// Shared definitions for the EX-stage iterative divider.
//   - div_state_e : DIV_IDLE / DIV_CALC / DIV_DONE 2-bit state encodings
//   - DIV_XLEN, DIV_CNT_W, DIV_ITER : default widths and iteration count
//   - div_mag()   : two's-complement magnitude of an operand
package ex_iter_divider_pkg;

  localparam int DIV_XLEN  = 32;
  localparam int DIV_CNT_W = 6;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of v; only negated when the op is signed and v is negative.
  // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
  function automatic logic [DIV_XLEN-1:0] div_mag(input logic [DIV_XLEN-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DIV_XLEN-1]) ? (~v + DIV_XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_iter_divider_core.sv
// div_restoring_core: unsigned radix-2 restoring divider datapath.
// Performs XLEN shift/trial-subtract steps, one per clock.
// Ports:
//   clk, resetn          clock, async active-low reset
//   start_i              load operands, clear counter, begin iterating
//   cancel_i             abort iteration (wins over start_i)
//   dividend_i/divisor_i unsigned magnitudes
//   last_o               the step executing this cycle is the final one
//   quo_o / rem_o        unsigned quotient / remainder (valid after last step)
module div_restoring_core
  import ex_iter_divider_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            cancel_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // Shift/trial are XLEN+1 wide so the trial subtract keeps its borrow bit.
  logic [XLEN:0] shifted, trial;
  logic          no_borrow;

  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    trial     = shifted - {1'b0, dvs_q};
    no_borrow = ~trial[XLEN];
  end

  assign last_o = run_q && (cnt_q == CNT_W'(XLEN-1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (cancel_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      // When no borrow the remainder fits in XLEN bits (it is < divisor).
      rem_q <= no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], no_borrow};
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_iter_divider.sv
// ex_iter_divider: multi-cycle 32-bit div.w / mod.w / div.wu / mod.wu for EX.
// Magnitudes go through div_restoring_core; signs, divide-by-zero override
// and the valid/ready handshake live here.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   in_valid / in_ready         operation handshake (ready only in IDLE)
//   op_signed, op_mod           signed op / return remainder
//   src1, src2                  dividend, divisor
//   cancel                      flush; aborts any in-flight op
//   busy                        op accepted, result not yet consumed
//   out_valid / out_ready       result handshake
//   result                      quotient or remainder
// Build option: DIV_EARLY_OUT_EN -- skip the iterations when the divisor is
// zero or |src1| < |src2| (results unchanged, latency 1 instead of 33).
module ex_iter_divider
  import ex_iter_divider_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic            op_mod,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            cancel,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q;
  logic            in_ready_q, busy_q, out_valid_q;
  logic [XLEN-1:0] result_q, src1_q;
  logic            qneg_q, rneg_q, mod_q, dvz_q, early_q;

  logic [XLEN-1:0] a_mag, b_mag, core_quo, core_rem;
  logic            accept, early_go, core_last;
  logic [XLEN-1:0] q_fix, r_fix, quo_res, rem_res, result_d;

  assign a_mag  = div_mag(src1, op_signed);
  assign b_mag  = div_mag(src2, op_signed);
  assign accept = in_valid & in_ready_q & ~cancel;

`ifdef DIV_EARLY_OUT_EN
  assign early_go = (src2 == '0) || (a_mag < b_mag);
`else
  assign early_go = 1'b0;
`endif

  div_restoring_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept & ~early_go),
    .cancel_i   (cancel),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .last_o     (core_last),
    .quo_o      (core_quo),
    .rem_o      (core_rem)
  );

  // Sign fix-up. Two's-complement negation of zero is zero, so zero results
  // are never turned negative.
  always_comb begin
    q_fix    = qneg_q ? (~core_quo + XLEN'(1)) : core_quo;
    r_fix    = rneg_q ? (~core_rem + XLEN'(1)) : core_rem;
    // Divide-by-zero and early-out both leave the dividend as remainder.
    quo_res  = dvz_q ? '1 : (early_q ? '0 : q_fix);
    rem_res  = (dvz_q | early_q) ? src1_q : r_fix;
    result_d = mod_q ? rem_res : quo_res;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= DIV_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      src1_q      <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      mod_q       <= 1'b0;
      dvz_q       <= 1'b0;
      early_q     <= 1'b0;
    end else if (cancel) begin
      state_q     <= DIV_IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (accept) begin
          src1_q     <= src1;
          qneg_q     <= op_signed & (src1[XLEN-1] ^ src2[XLEN-1]);
          rneg_q     <= op_signed & src1[XLEN-1];
          mod_q      <= op_mod;
          dvz_q      <= (src2 == '0);
          early_q    <= early_go;
          busy_q     <= 1'b1;
          in_ready_q <= 1'b0;
          state_q    <= early_go ? DIV_DONE : DIV_CALC;
        end
        DIV_CALC: if (core_last) state_q <= DIV_DONE;
        DIV_DONE: begin
          // First DONE cycle registers the fixed-up result; then hold.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ex_iter_divider.sv
module tb_ex_iter_divider;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, op_signed = 1'b0, op_mod = 1'b0;
  logic        cancel = 1'b0, out_ready = 1'b0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        in_ready, busy, out_valid;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  ex_iter_divider dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .op_mod    (op_mod),
    .src1      (src1),
    .src2      (src2),
    .cancel    (cancel),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mag(input logic s, input logic [31:0] v);
    return (s && v[31]) ? 32'd0 - v : v;
  endfunction

  function automatic logic [31:0] ref_div(input logic s, input logic m,
                                          input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return m ? a : 32'hFFFF_FFFF;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return m ? 32'd0 : 32'h8000_0000;
      return m ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return m ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(s, a) < mag(s, b)) return 1;
`endif
    return 33;
  endfunction

  // Drives one op, waits for out_valid (bounded), consumes it. lat counts
  // cycles from the accept edge to the first cycle out_valid is seen.
  task automatic do_op(input logic s, input logic m, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; op_signed = s; op_mod = m; src1 = a; src2 = b; out_ready = 1'b0;
    while (!in_ready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    #12;
    n_tests++;
    if ({in_ready, busy, out_valid, result} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset rdy/busy/vld/res got %b%b%b/%h want 100/00000000", in_ready, busy, out_valid, result);
    end
    #10 resetn = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat;
    do_op(1'b0, 1'b0, 32'd100, 32'd7, r, lat);
    n_tests++; if (r !== 32'd14) begin n_fail++; $display("FAIL udiv_100_7 got %h want %h", r, 32'd14); end
    n_tests++; if (lat !== 33) begin n_fail++; $display("FAIL udiv_latency got %0d want 33", lat); end
    do_op(1'b0, 1'b1, 32'd100, 32'd7, r, lat);
    n_tests++; if (r !== 32'd2) begin n_fail++; $display("FAIL umod_100_7 got %h want %h", r, 32'd2); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat;
    logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] b [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic        m [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, m[i], a[i], b[i], r, lat);
      n_tests++;
      if (r !== e[i]) begin n_fail++; $display("FAIL signed_%0d got %h want %h", i, r, e[i]); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] r, e; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(i[1], i[0], 32'h1234_5678, 32'd0, r, lat);
      e = i[0] ? 32'h1234_5678 : 32'hFFFF_FFFF;
      n_tests++;
      if (r !== e) begin n_fail++; $display("FAIL divzero_s%0d_m%0d got %h want %h", i[1], i[0], r, e); end
      n_tests++;
      if (lat !== ref_lat(i[1], 32'h1234_5678, 32'd0)) begin
        n_fail++; $display("FAIL divzero_latency got %0d want %0d", lat, ref_lat(i[1], 32'h1234_5678, 32'd0));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat;
    logic [31:0] e [4] = '{32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      do_op(i[1], i[0], 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
      n_tests++;
      if (r !== e[i]) begin n_fail++; $display("FAIL overflow_s%0d_m%0d got %h want %h", i[1], i[0], r, e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held; int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src1 = 32'd1000; src2 = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    held = result;
    n_tests++;
    if (held !== 32'd111) begin n_fail++; $display("FAIL bp_result got %h want %h", held, 32'd111); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, busy, result} !== {1'b1, 1'b1, held}) begin
        n_fail++; $display("FAIL bp_hold_%0d vld/busy/res got %b%b/%h want 11/%h", c, out_valid, busy, result, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL bp_release rdy/busy/vld got %b%b%b want 100", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r; int lat; bit seen;
    @(posedge clk); #1;
    in_valid = 1'b1; op_signed = 1'b0; op_mod = 1'b0; src1 = 32'hFFFF_FFFF; src2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    // Cancel with a competing in_valid: the new op must be dropped.
    cancel = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_fail++; $display("FAIL cancel_idle rdy/busy/vld got %b%b%b want 100", in_ready, busy, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL cancel_quiet got activity=1 want 0"); end
    do_op(1'b0, 1'b0, 32'd9, 32'd3, r, lat);
    n_tests++; if (r !== 32'd3) begin n_fail++; $display("FAIL after_cancel_9_3 got %h want %h", r, 32'd3); end
  endtask

  task automatic test_async_reset();
    bit seen;
    @(posedge clk); #1;
    in_valid = 1'b1; op_signed = 1'b1; op_mod = 1'b0; src1 = 32'd5000; src2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, busy, out_valid, result} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset rdy/busy/vld/res got %b%b%b/%h want 100/00000000", in_ready, busy, out_valid, result);
    end
    #3 resetn = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid || busy) seen = 1'b1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL reset_quiet got activity=1 want 0"); end
  endtask

  task automatic test_early_out();
    logic [31:0] r; int lat, want;
`ifdef DIV_EARLY_OUT_EN
    want = 1;
`else
    want = 33;
`endif
    do_op(1'b0, 1'b0, 32'd3, 32'd10, r, lat);
    n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL early_3_10 got %h want 00000000", r); end
    n_tests++; if (lat !== want) begin n_fail++; $display("FAIL early_latency got %0d want %0d", lat, want); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, e; logic s, m; int lat, el;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom); m = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 5 == 0) a = a >> $urandom_range(8, 31);
      do_op(s, m, a, b, r, lat);
      e  = ref_div(s, m, a, b);
      el = ref_lat(s, a, b);
      n_tests++;
      if (r !== e) begin n_fail++; $display("FAIL rand_%0d s%0d m%0d %h/%h got %h want %h", i, s, m, a, b, r, e); end
      n_tests++;
      if (lat !== el) begin n_fail++; $display("FAIL rand_lat_%0d got %0d want %0d", i, lat, el); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_cancel();
    test_async_reset();
    test_early_out();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
